// File: rtl/rename_stage.sv
// Register-rename stage: RAT lookup/update plus a circular free list of physical registers.
// Renamed instruction is held in an output register with a valid/ready handshake to dispatch.
module rename_stage #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PREG_W    = 6
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(ARCH_REGS)-1:0] srcReg1_in,
    input  logic [$clog2(ARCH_REGS)-1:0] srcReg2_in,
    input  logic [$clog2(ARCH_REGS)-1:0] destReg_in,
    input  logic                         regWrite_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PREG_W-1:0]            psrc1_out,
    output logic [PREG_W-1:0]            psrc2_out,
    output logic [PREG_W-1:0]            pdest_out,
    output logic [PREG_W-1:0]            old_pdest_out,
    output logic                         regWrite_out,
    input  logic                         retire_valid,
    input  logic [PREG_W-1:0]            retire_preg,
    output logic [PREG_W:0]              free_count
);

    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FL_PTR_W = $clog2(FL_DEPTH);
    localparam int CNT_W    = PREG_W + 1;

    logic [PREG_W-1:0]   rat_q [ARCH_REGS];
    logic [PREG_W-1:0]   rat_d [ARCH_REGS];
    logic [PREG_W-1:0]   fl_q  [FL_DEPTH];
    logic [PREG_W-1:0]   fl_d  [FL_DEPTH];
    logic [FL_PTR_W-1:0] head_q, head_d;
    logic [FL_PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                out_valid_q, out_valid_d;
    logic [PREG_W-1:0]   psrc1_q, psrc1_d;
    logic [PREG_W-1:0]   psrc2_q, psrc2_d;
    logic [PREG_W-1:0]   pdest_q, pdest_d;
    logic [PREG_W-1:0]   old_pdest_q, old_pdest_d;
    logic                reg_write_q, reg_write_d;

    logic accept;
    logic alloc;
    logic push;
    logic fl_full;

    function automatic logic [FL_PTR_W-1:0] ptr_inc(input logic [FL_PTR_W-1:0] p);
        if (p == FL_PTR_W'(FL_DEPTH - 1)) begin
            return '0;
        end
        return p + FL_PTR_W'(1);
    endfunction

    // Stall depends only on the registered count, so a same-cycle retire cannot unblock an empty list.
    assign in_ready = (!out_valid_q || out_ready) && (count_q != '0);
    assign accept   = in_valid && in_ready;
    assign alloc    = accept && regWrite_in && (destReg_in != '0);
    assign fl_full  = (count_q == CNT_W'(FL_DEPTH));
    assign push     = retire_valid && (retire_preg != '0) && !(fl_full && !alloc);

    always_comb begin
        rat_d   = rat_q;
        fl_d    = fl_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(alloc);

        if (alloc) begin
            rat_d[destReg_in] = fl_q[head_q];
            head_d            = ptr_inc(head_q);
        end
        // When full, tail equals head; the popped value above is the pre-write head entry.
        if (push) begin
            fl_d[tail_q] = retire_preg;
            tail_d       = ptr_inc(tail_q);
        end
        rat_d[0] = '0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        psrc1_d     = psrc1_q;
        psrc2_d     = psrc2_q;
        pdest_d     = pdest_q;
        old_pdest_d = old_pdest_q;
        reg_write_d = reg_write_q;

        if (accept) begin
            out_valid_d = 1'b1;
            psrc1_d     = rat_q[srcReg1_in];
            psrc2_d     = rat_q[srcReg2_in];
            reg_write_d = regWrite_in;
            if (alloc) begin
                pdest_d     = fl_q[head_q];
                old_pdest_d = rat_q[destReg_in];
            end else begin
                pdest_d     = '0;
                old_pdest_d = '0;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= PREG_W'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PREG_W'(ARCH_REGS + i);
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= CNT_W'(FL_DEPTH);
            out_valid_q <= 1'b0;
            psrc1_q     <= '0;
            psrc2_q     <= '0;
            pdest_q     <= '0;
            old_pdest_q <= '0;
            reg_write_q <= 1'b0;
        end else begin
            rat_q       <= rat_d;
            fl_q        <= fl_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            psrc1_q     <= psrc1_d;
            psrc2_q     <= psrc2_d;
            pdest_q     <= pdest_d;
            old_pdest_q <= old_pdest_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign psrc1_out     = psrc1_q;
    assign psrc2_out     = psrc2_q;
    assign pdest_out     = pdest_q;
    assign old_pdest_out = old_pdest_q;
    assign regWrite_out  = reg_write_q;
    assign free_count    = count_q;

endmodule

// File: doc/rename_stage.md
# rename_stage

Register-rename stage sitting directly downstream of the ID/EX pipeline register in the out-of-order core. It accepts one decoded instruction per cycle, maps its architectural source and destination registers to physical registers through a register alias table (RAT), and allocates a new physical destination from a free-list FIFO. It presents the renamed instruction to dispatch through a registered valid/ready output. Physical registers are returned to the free list by the retire interface.

## Interface
- ARCH_REGS, 32, number of architectural registers (x0..x31)
- PHYS_REGS, 64, number of physical registers
- PREG_W, 6, physical register index width (log2 PHYS_REGS)
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- srcReg1_in, srcReg2_in, destReg_in  in  5 each  architectural registers
- regWrite_in  in  1  instruction writes destReg_in
- out_valid  out  1  renamed instruction present
- out_ready  in  1  dispatch accepts the output
- psrc1_out, psrc2_out  out  PREG_W each  physical sources
- pdest_out  out  PREG_W  allocated physical destination (0 if none)
- old_pdest_out  out  PREG_W  previous mapping of destReg_in (0 if none)
- regWrite_out  out  1  registered copy of regWrite_in
- retire_valid  in  1  free the register on retire_preg
- retire_preg  in  PREG_W  physical register to return to the free list
- free_count  out  PREG_W+1  number of free physical registers

## Operation
- Reset (rstn=0 at clock edge): RAT[i]=i for i=0..31; free list holds 32..63 in ascending order, head=0, tail=0, free_count=32; out_valid=0, psrc1_out=psrc2_out=pdest_out=old_pdest_out=0, regWrite_out=0. Reset asserted mid-operation discards any held output and all mappings.
- Free list: circular FIFO, depth PHYS_REGS-ARCH_REGS (32), head/tail pointers wrap modulo depth.
- in_ready = (!out_valid || out_ready) && (free_count != 0); uses registered free_count only. Stall applies even to instructions needing no allocation.
- Accept = in_valid && in_ready. On accept:
  - psrc1_out=RAT[srcReg1_in], psrc2_out=RAT[srcReg2_in], read before this instruction's RAT update (src==dest gets old mapping).
  - alloc = regWrite_in && destReg_in != 0. If alloc: pdest_out=free list head, old_pdest_out=RAT[destReg_in], RAT[destReg_in]<=head entry, head advances. Else pdest_out=0, old_pdest_out=0, RAT unchanged.
  - out_valid<=1, regWrite_out<=regWrite_in.
- Output hold: out_valid && !out_ready keeps all outputs stable; out_valid && out_ready && !accept drops out_valid to 0 next cycle.
- Retire: retire_valid && retire_preg != 0 writes retire_preg at tail, tail advances. retire_preg=0 ignored. Retire when free_count=32 and no same-cycle alloc is dropped (no state change).
- free_count next = free_count + push - pop; simultaneous alloc and retire leaves it unchanged, entry popped is the old head even if free_count was 1.
- RAT[0] is constant 0; never written.

## Timing
- Latency 1 cycle: accept at edge N, renamed outputs valid after edge N.
- Throughput 1 instruction/cycle while free_count>0 and output drained.
- RAT update and free-list pop visible to the instruction accepted at edge N+1 (back-to-back dependents see new mapping).
- Retired register becomes allocatable the cycle after retire (in_ready reflects updated count next cycle).
- free_count=0: in_ready=0 until a retire edge raises the count.

## Test plan
- Reset, then rename srcReg1=3, srcReg2=4, destReg=5, regWrite=1 -> psrc1=3, psrc2=4, pdest=32, old_pdest=5, free_count=31.
- Back-to-back: add x5 then add x6 using x5 -> second psrc1=32, pdest=33, old_pdest=6.
- src==dest: x7 = x7+x7 after reset -> psrc1=psrc2=7, pdest=32, RAT[7]=32 next cycle.
- destReg=0 or regWrite=0 -> pdest=0, old_pdest=0, free_count unchanged.
- 32 allocations, no retire -> free_count=0, in_ready=0; retire_preg=5 -> next cycle in_ready=1, next alloc gets pdest=5 (wrap).
- out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no allocation; out_ready=1 -> resumes, simultaneous retire+alloc keeps free_count.
